bus_arb2: RTL and testbench
===========================

BUS_ARB2 -- requirements
Module: bus_arb2

Interface
REQ-001 SHALL have parameter RD_FIFO_POW, default 2, meaning log2 of the maximum number of outstanding reads (depth D = 2**RD_FIFO_POW).
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have, for each master port k in {0,1}, ports mk_req_i in 1; mk_we_i in 1; mk_addr_bi in 32; mk_be_bi in 4; mk_wdata_bi in 32. These are the master's request fields.
REQ-005 SHALL have, for each k, ports mk_ack_o out 1 (request accepted) and mk_resp_o out 1 (read data valid), plus mk_rdata_bo out 32.
REQ-006 SHALL have slave-side ports s_req_o out 1; s_we_o out 1; s_addr_bo out 32; s_be_bo out 4; s_wdata_bo out 32; s_ack_i in 1; s_resp_i in 1; s_rdata_bi in 32.
REQ-007 SHALL have port err_o  output  1, a sticky flag for a spurious slave response.

Function
REQ-008 SHALL use split-bus protocol on all ports: a request transfers in a cycle where req and ack are both 1. The master holds req and its fields stable until ack. A read returns exactly one resp pulse with rdata, in request order, in any later cycle.
REQ-009 SHALL select one master per cycle as grant gid, and drive s_req_o/s_we_o/s_addr_bo/s_be_bo/s_wdata_bo combinationally from master gid; when no master is eligible, s_req_o=0 and the other slave outputs are 0.
REQ-010 SHALL drive mk_ack_o = s_ack_i AND s_req_o AND (gid==k); the non-granted master's ack SHALL be 0.
REQ-011 SHALL treat master k as eligible when mk_req_i=1 and, if mk_we_i=0, the read-ID FIFO is not full.
REQ-012 SHALL implement a lock (states UNLOCKED/LOCKED with a locked_id register). In UNLOCKED, gid SHALL be chosen among eligible masters by round-robin pointer rr. If s_req_o=1 and s_ack_i=0, the next state SHALL be LOCKED with locked_id=gid.
REQ-013 In LOCKED, gid SHALL be locked_id regardless of the other master. The state SHALL return to UNLOCKED in the cycle after the handshake (s_req_o AND s_ack_i).
REQ-014 SHALL resolve the round-robin choice as follows: both masters eligible → gid=rr; one eligible → that master. After each handshake, rr SHALL be updated to the master that did not win.
REQ-015 SHALL push gid into a D-entry read-ID FIFO on each read handshake (s_req_o, s_ack_i, s_we_o=0); writes SHALL NOT push.
REQ-016 On s_resp_i=1 with FIFO non-empty, SHALL pop the head id h, drive mh_resp_o=1 and mh_rdata_bo=s_rdata_bi combinationally in that cycle. The other master's resp_o SHALL be 0 and its rdata_bo 0.
REQ-017 On s_resp_i=1 with FIFO empty, SHALL assert no mk_resp_o, leave the FIFO unchanged, and set err_o=1 from the next cycle until reset.
REQ-018 SHALL support simultaneous push and pop in one cycle, including when the FIFO is full, with the count unchanged. When the FIFO is empty, a same-cycle push SHALL NOT satisfy the same-cycle resp, and REQ-017 applies.
REQ-019 SHALL NOT grant a read while the FIFO is full, even if a same-cycle pop is occurring. A pending read from the locked master SHALL keep the lock, with s_req_o=1 already issued.
REQ-020 SHALL use pointer arithmetic modulo D (RD_FIFO_POW-bit wrap) and a (RD_FIFO_POW+1)-bit occupancy count, range 0..D.

Reset
REQ-021 On rst_i=1 at a clock edge, SHALL set state=UNLOCKED, rr=0, FIFO empty (pointers and count 0), err_o=0.
REQ-022 During and after reset, outputs SHALL follow REQ-009/010/016 from the reset register values. Reads outstanding at reset are discarded, and their later responses set err_o.

Verification
REQ-023 Single master, m0 write addr 0x0, wdata 0x1234, s_ack_i tied 1 → s_req_o same cycle, m0_ack_o=1, no FIFO push, m1_ack_o=0.
REQ-024 Both masters issue continuous reads with s_ack_i=1 and resp 1 cycle later → grants alternate m0,m1,m0,..., and each resp is routed to the issuing master with its rdata.
REQ-025 m1 reads while s_ack_i is held 0 for 3 cycles, and m0 raises req in cycle 2 → gid stays 1 (LOCKED) until the ack. m0 is granted the next cycle.
REQ-026 With D=4, m0 issues 4 reads with no resp → 5th read not granted (s_req_o=0) while m1 writes are still granted. A single resp frees one slot and the read is granted the next cycle.
REQ-027 s_resp_i pulse with the FIFO empty → no mk_resp_o, err_o=1 next cycle and held. rst_i pulse → err_o=0, rr=0.
REQ-028 rst_i asserted with 2 reads outstanding → FIFO empty after reset. The two late resps raise err_o, and neither master sees resp.

Source files
------------

// File: rtl/bus_arb2.sv
// bus_arb2: two-master split-bus arbiter with lock-on-stall,
// round-robin grant and an in-order read-ID FIFO for response routing.
module bus_arb2 #(
  parameter int unsigned RD_FIFO_POW = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_bi,
  input  logic [3:0]  m0_be_bi,
  input  logic [31:0] m0_wdata_bi,
  output logic        m0_ack_o,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_bo,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_bi,
  input  logic [3:0]  m1_be_bi,
  input  logic [31:0] m1_wdata_bi,
  output logic        m1_ack_o,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_bo,

  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_bo,
  output logic [3:0]  s_be_bo,
  output logic [31:0] s_wdata_bo,
  input  logic        s_ack_i,
  input  logic        s_resp_i,
  input  logic [31:0] s_rdata_bi,

  output logic        err_o
);

  localparam int unsigned D = 1 << RD_FIFO_POW;

  localparam logic [RD_FIFO_POW-1:0] PTR_ONE  = 1;
  localparam logic [RD_FIFO_POW:0]   CNT_ONE  = 1;
  localparam logic [RD_FIFO_POW:0]   CNT_FULL = D[RD_FIFO_POW:0];

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   lock_id_q, lock_id_d;
  logic   rr_q, rr_d;
  logic   err_q, err_d;

  logic [RD_FIFO_POW-1:0] wptr_q, wptr_d;
  logic [RD_FIFO_POW-1:0] rptr_q, rptr_d;
  logic [RD_FIFO_POW:0]   cnt_q, cnt_d;
  logic                   id_mem_q [D];

  logic fifo_full;
  logic fifo_empty;
  logic elig0;
  logic elig1;
  logic gid;
  logic gnt;
  logic hs;
  logic push;
  logic pop;
  logic head_id;

  assign fifo_full  = (cnt_q == CNT_FULL);
  assign fifo_empty = (cnt_q == '0);

  // A read may only be presented while a FIFO slot is free.
  assign elig0 = m0_req_i & (m0_we_i | ~fifo_full);
  assign elig1 = m1_req_i & (m1_we_i | ~fifo_full);

  // Grant select: locked master wins outright, else round-robin.
  always_comb begin
    gid = 1'b0;
    gnt = 1'b0;
    unique case (state_q)
      LOCKED: begin
        gid = lock_id_q;
        gnt = lock_id_q ? elig1 : elig0;
      end
      default: begin
        gnt = elig0 | elig1;
        gid = (elig0 & elig1) ? rr_q : elig1;
      end
    endcase
  end

  // Slave-side request mux; all fields zero when nothing is granted.
  always_comb begin
    s_req_o    = gnt;
    s_we_o     = 1'b0;
    s_addr_bo  = '0;
    s_be_bo    = '0;
    s_wdata_bo = '0;
    if (gnt) begin
      unique case (1'b1)
        gid: begin
          s_we_o     = m1_we_i;
          s_addr_bo  = m1_addr_bi;
          s_be_bo    = m1_be_bi;
          s_wdata_bo = m1_wdata_bi;
        end
        default: begin
          s_we_o     = m0_we_i;
          s_addr_bo  = m0_addr_bi;
          s_be_bo    = m0_be_bi;
          s_wdata_bo = m0_wdata_bi;
        end
      endcase
    end
  end

  assign hs   = s_req_o & s_ack_i;
  assign push = hs & ~s_we_o;
  assign pop  = s_resp_i & ~fifo_empty;

  assign head_id = id_mem_q[rptr_q];

  assign m0_ack_o = hs & ~gid;
  assign m1_ack_o = hs & gid;

  assign m0_resp_o   = pop & ~head_id;
  assign m1_resp_o   = pop & head_id;
  assign m0_rdata_bo = {32{m0_resp_o}} & s_rdata_bi;
  assign m1_rdata_bo = {32{m1_resp_o}} & s_rdata_bi;

  assign err_o = err_q;

  // Lock on a stalled request, release once it is accepted.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    unique case (state_q)
      UNLOCKED: begin
        if (s_req_o & ~s_ack_i) begin
          state_d   = LOCKED;
          lock_id_d = gid;
        end
      end
      LOCKED: begin
        if (hs) begin
          state_d = UNLOCKED;
        end
      end
      default: begin
        state_d = UNLOCKED;
      end
    endcase
  end

  // Round-robin pointer, FIFO pointers/occupancy and sticky error.
  always_comb begin
    rr_d   = hs ? ~gid : rr_q;
    wptr_d = push ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d = pop ? (rptr_q + PTR_ONE) : rptr_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | (s_resp_i & fifo_empty);
  end

  // Control and pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= UNLOCKED;
      lock_id_q <= 1'b0;
      rr_q      <= 1'b0;
      err_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_q      <= rr_d;
      err_q     <= err_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // ID storage; contents are meaningless outside the valid window.
  always_ff @(posedge clk_i) begin
    if (push & ~rst_i) begin
      id_mem_q[wptr_q] <= gid;
    end
  end

endmodule

// File: tb/tb_bus_arb2.sv
// tb_bus_arb2: directed vectors for bus_arb2 with hand-computed
// expectations, checked by immediate assertions each cycle.
module tb_bus_arb2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_ack, m0_resp, m1_ack, m1_resp;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we, s_ack, s_resp;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic        err;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bus_arb2 #(.RD_FIFO_POW(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .m0_req_i    (m0_req),
    .m0_we_i     (m0_we),
    .m0_addr_bi  (m0_addr),
    .m0_be_bi    (m0_be),
    .m0_wdata_bi (m0_wdata),
    .m0_ack_o    (m0_ack),
    .m0_resp_o   (m0_resp),
    .m0_rdata_bo (m0_rdata),
    .m1_req_i    (m1_req),
    .m1_we_i     (m1_we),
    .m1_addr_bi  (m1_addr),
    .m1_be_bi    (m1_be),
    .m1_wdata_bi (m1_wdata),
    .m1_ack_o    (m1_ack),
    .m1_resp_o   (m1_resp),
    .m1_rdata_bo (m1_rdata),
    .s_req_o     (s_req),
    .s_we_o      (s_we),
    .s_addr_bo   (s_addr),
    .s_be_bo     (s_be),
    .s_wdata_bo  (s_wdata),
    .s_ack_i     (s_ack),
    .s_resp_i    (s_resp),
    .s_rdata_bi  (s_rdata),
    .err_o       (err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clr();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_be = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_be = 0; m1_wdata = 0;
    s_ack = 0; s_resp = 0; s_rdata = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst = 1;
    nxt();
    nxt();
    #1;
    chk("rst_sreq", s_req, 0);
    chk("rst_err", err, 0);
    chk("rst_ack0", m0_ack, 0);
    rst = 0;

    // both masters stream reads, resp one cycle later
    nxt();
    m0_req = 1; m0_addr = 32'h100; m0_be = 4'hf;
    m1_req = 1; m1_addr = 32'h200; m1_be = 4'hf;
    s_ack = 1;
    #1;
    chk("rr0_sreq", s_req, 1);
    chk("rr0_addr", s_addr, 32'h100);
    chk("rr0_ack0", m0_ack, 1);
    chk("rr0_ack1", m1_ack, 0);
    chk("rr0_resp0", m0_resp, 0);
    nxt();
    s_resp = 1; s_rdata = 32'hA0;
    #1;
    chk("rr1_addr", s_addr, 32'h200);
    chk("rr1_ack1", m1_ack, 1);
    chk("rr1_ack0", m0_ack, 0);
    chk("rr1_resp0", m0_resp, 1);
    chk("rr1_rdata0", m0_rdata, 32'hA0);
    chk("rr1_resp1", m1_resp, 0);
    chk("rr1_rdata1", m1_rdata, 0);
    nxt();
    s_rdata = 32'hB1;
    #1;
    chk("rr2_addr", s_addr, 32'h100);
    chk("rr2_ack0", m0_ack, 1);
    chk("rr2_resp1", m1_resp, 1);
    chk("rr2_rdata1", m1_rdata, 32'hB1);
    chk("rr2_resp0", m0_resp, 0);
    nxt();
    s_rdata = 32'hC0;
    #1;
    chk("rr3_addr", s_addr, 32'h200);
    chk("rr3_ack1", m1_ack, 1);
    chk("rr3_resp0", m0_resp, 1);
    chk("rr3_rdata0", m0_rdata, 32'hC0);
    nxt();
    clr();
    s_resp = 1; s_rdata = 32'hD1;
    #1;
    chk("rr4_sreq", s_req, 0);
    chk("rr4_resp1", m1_resp, 1);
    chk("rr4_rdata1", m1_rdata, 32'hD1);
    chk("rr4_resp0", m0_resp, 0);

    // single write from m0
    nxt();
    clr();
    m0_req = 1; m0_we = 1; m0_addr = 0; m0_be = 4'hf;
    m0_wdata = 32'h1234; s_ack = 1;
    #1;
    chk("wr_sreq", s_req, 1);
    chk("wr_swe", s_we, 1);
    chk("wr_addr", s_addr, 0);
    chk("wr_wdata", s_wdata, 32'h1234);
    chk("wr_be", {28'h0, s_be}, 32'hf);
    chk("wr_ack0", m0_ack, 1);
    chk("wr_ack1", m1_ack, 0);
    nxt();
    clr();
    #1;
    chk("idle_sreq", s_req, 0);
    chk("idle_wdata", s_wdata, 0);
    chk("idle_addr", s_addr, 0);
    chk("idle_err", err, 0);

    // lock: m1 write moves rr to 0, then m1 read stalls
    nxt();
    clr();
    m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_be = 4'h3;
    m1_wdata = 32'h5555; s_ack = 1;
    #1;
    chk("lk_w_ack1", m1_ack, 1);
    chk("lk_w_swe", s_we, 1);
    nxt();
    clr();
    m1_req = 1; m1_addr = 32'h300; m1_be = 4'hf;
    #1;
    chk("lk1_sreq", s_req, 1);
    chk("lk1_addr", s_addr, 32'h300);
    chk("lk1_ack1", m1_ack, 0);
    nxt();
    m0_req = 1; m0_addr = 32'h104; m0_be = 4'hf;
    #1;
    chk("lk2_addr", s_addr, 32'h300);
    chk("lk2_ack0", m0_ack, 0);
    nxt();
    #1;
    chk("lk3_addr", s_addr, 32'h300);
    chk("lk3_sreq", s_req, 1);
    nxt();
    s_ack = 1;
    #1;
    chk("lk4_addr", s_addr, 32'h300);
    chk("lk4_ack1", m1_ack, 1);
    chk("lk4_ack0", m0_ack, 0);
    nxt();
    m1_req = 0;
    #1;
    chk("lk5_addr", s_addr, 32'h104);
    chk("lk5_ack0", m0_ack, 1);
    nxt();
    clr();
    s_resp = 1; s_rdata = 32'hE1;
    #1;
    chk("lk6_resp1", m1_resp, 1);
    chk("lk6_rdata1", m1_rdata, 32'hE1);
    chk("lk6_resp0", m0_resp, 0);
    nxt();
    s_rdata = 32'hF0;
    #1;
    chk("lk7_resp0", m0_resp, 1);
    chk("lk7_rdata0", m0_rdata, 32'hF0);
    chk("lk7_resp1", m1_resp, 0);

    // fill the read-ID FIFO from m0
    nxt();
    clr();
    m0_req = 1; m0_addr = 32'h500; m0_be = 4'hf; s_ack = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fill_ack0", m0_ack, 1);
      nxt();
    end
    m1_req = 1; m1_we = 1; m1_addr = 32'h600; m1_be = 4'hf;
    #1;
    chk("full_waddr", s_addr, 32'h600);
    chk("full_wwe", s_we, 1);
    chk("full_ack1", m1_ack, 1);
    chk("full_ack0", m0_ack, 0);
    nxt();
    m1_req = 0;
    #1;
    chk("full_sreq", s_req, 0);
    chk("full_ack0b", m0_ack, 0);
    nxt();
    s_resp = 1; s_rdata = 32'h11;
    #1;
    chk("full_pop_sreq", s_req, 0);
    chk("full_pop_resp0", m0_resp, 1);
    chk("full_pop_rdata", m0_rdata, 32'h11);
    nxt();
    s_resp = 0;
    #1;
    chk("refill_sreq", s_req, 1);
    chk("refill_addr", s_addr, 32'h500);
    chk("refill_ack0", m0_ack, 1);
    nxt();
    clr();
    s_resp = 1;
    for (int i = 0; i < 4; i++) begin
      s_rdata = 32'h20 + i;
      #1;
      chk("drain_resp0", m0_resp, 1);
      chk("drain_rdata0", m0_rdata, 32'h20 + i);
      chk("drain_resp1", m1_resp, 0);
      nxt();
    end

    // spurious response with empty FIFO
    clr();
    s_resp = 1; s_rdata = 32'h77;
    #1;
    chk("sp_resp0", m0_resp, 0);
    chk("sp_resp1", m1_resp, 0);
    chk("sp_err_now", err, 0);
    nxt();
    clr();
    #1;
    chk("sp_err_next", err, 1);
    nxt();
    #1;
    chk("sp_err_held", err, 1);
    nxt();
    rst = 1;
    nxt();
    rst = 0;
    m0_req = 1; m0_we = 1; m0_addr = 32'h700; m0_be = 4'hf;
    m1_req = 1; m1_we = 1; m1_addr = 32'h800; m1_be = 4'hf;
    s_ack = 1;
    #1;
    chk("rst_err_clr", err, 0);
    chk("rst_rr_ack0", m0_ack, 1);
    chk("rst_rr_ack1", m1_ack, 0);
    chk("rst_rr_addr", s_addr, 32'h700);

    // reads outstanding across reset are discarded
    nxt();
    clr();
    m1_req = 1; m1_addr = 32'h900; m1_be = 4'hf; s_ack = 1;
    #1;
    chk("or_ack1", m1_ack, 1);
    nxt();
    clr();
    m0_req = 1; m0_addr = 32'h904; m0_be = 4'hf; s_ack = 1;
    #1;
    chk("or_ack0", m0_ack, 1);
    nxt();
    clr();
    rst = 1;
    nxt();
    rst = 0;
    s_resp = 1; s_rdata = 32'h33;
    #1;
    chk("or_r1_resp0", m0_resp, 0);
    chk("or_r1_resp1", m1_resp, 0);
    chk("or_r1_err", err, 0);
    nxt();
    s_rdata = 32'h44;
    #1;
    chk("or_r2_resp0", m0_resp, 0);
    chk("or_r2_resp1", m1_resp, 0);
    chk("or_r2_err", err, 1);
    nxt();
    clr();
    #1;
    chk("or_err_held", err, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
